// File: rtl/trap_unit_if.sv
// Trap controller bus: CSR access port, execute-stage trap sources and trap outputs.
// The slave side is the trap unit; the master side is the core/CSR file.
interface trap_unit_if;
    logic        trap_rd_en;
    logic        trap_wr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wr_data;
    logic [31:0] trap_rd_data;
    logic        global_mie;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] fault_addr;
    logic        illegal_inst;
    logic        inst_misaligned;
    logic        ecall;
    logic        ebreak;
    logic        load_misaligned;
    logic        store_misaligned;
    logic        msip;
    logic        mtip;
    logic        meip_async;
    logic        dbus_wait;
    logic        mret;
    logic        trap;
    logic [31:0] trap_target;
    logic [31:0] mepc_out;

    modport slave (
        input  trap_rd_en, trap_wr_en, csr_addr, csr_wr_data, global_mie,
        input  pc, inst, fault_addr,
        input  illegal_inst, inst_misaligned, ecall, ebreak, load_misaligned, store_misaligned,
        input  msip, mtip, meip_async, dbus_wait, mret,
        output trap_rd_data, trap, trap_target, mepc_out
    );

    modport master (
        output trap_rd_en, trap_wr_en, csr_addr, csr_wr_data, global_mie,
        output pc, inst, fault_addr,
        output illegal_inst, inst_misaligned, ecall, ebreak, load_misaligned, store_misaligned,
        output msip, mtip, meip_async, dbus_wait, mret,
        input  trap_rd_data, trap, trap_target, mepc_out
    );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap controller owning mtvec/mie/mip/mepc/mcause/mtval.
// Define RANGER_VECTORED_MTVEC_EN to make mtvec.MODE writable (vectored interrupts).
module trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    trap_unit_if.slave  bus
);

    typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    state_t      state_q, state_d;
    logic [31:0] mtvec_q;
    logic [31:0] mie_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic        meipSync1_q, meipSync2_q;

    logic [31:0] mipValue;
    logic [31:0] pendingBits;
    logic        intPending;
    logic        excValid;
    logic [3:0]  excCode;
    logic [31:0] excTval;
    logic [3:0]  intCode;
    logic        trapFire;
    logic        trapIsInt;
    logic [3:0]  trapCode;
    logic [31:0] trapBase;
    logic [1:0]  modeWrite;
    logic [31:0] rdData;

    assign mipValue    = {20'b0, meipSync2_q, 3'b0, bus.mtip, 3'b0, bus.msip, 3'b0};
    assign pendingBits = mipValue & mie_q;
    assign intPending  = bus.global_mie && (pendingBits != 32'b0);

    // Synchronous exceptions in fixed priority order, with their mtval source.
    always_comb begin
        excValid = 1'b1;
        excCode  = 4'd0;
        excTval  = 32'b0;
        if (bus.illegal_inst) begin
            excCode = 4'd2;
            excTval = bus.inst;
        end else if (bus.inst_misaligned) begin
            excCode = 4'd0;
            excTval = bus.fault_addr;
        end else if (bus.ecall) begin
            excCode = 4'd11;
        end else if (bus.ebreak) begin
            excCode = 4'd3;
        end else if (bus.store_misaligned) begin
            excCode = 4'd6;
            excTval = bus.fault_addr;
        end else if (bus.load_misaligned) begin
            excCode = 4'd4;
            excTval = bus.fault_addr;
        end else begin
            excValid = 1'b0;
        end
    end

    always_comb begin
        if (pendingBits[11])     intCode = 4'd11;
        else if (pendingBits[3]) intCode = 4'd3;
        else                     intCode = 4'd7;
    end

    // An interrupt waits in HOLD while the data bus stalls; mret only defers interrupts.
    always_comb begin
        state_d   = state_q;
        trapFire  = 1'b0;
        trapIsInt = 1'b0;
        case (state_q)
            RUN: begin
                if (excValid) begin
                    trapFire = 1'b1;
                    state_d  = FLUSH;
                end else if (intPending) begin
                    if (bus.dbus_wait) begin
                        state_d = HOLD;
                    end else if (!bus.mret) begin
                        trapFire  = 1'b1;
                        trapIsInt = 1'b1;
                        state_d   = FLUSH;
                    end
                end
            end
            HOLD: begin
                if (excValid) begin
                    trapFire = 1'b1;
                    state_d  = FLUSH;
                end else if (!intPending) begin
                    state_d = RUN;
                end else if (!bus.dbus_wait && !bus.mret) begin
                    trapFire  = 1'b1;
                    trapIsInt = 1'b1;
                    state_d   = FLUSH;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign trapCode = trapIsInt ? intCode : excCode;
    assign trapBase = {mtvec_q[31:2], 2'b00};

    always_comb begin
        bus.trap        = trapFire && !rst;
        bus.trap_target = 32'b0;
        if (bus.trap) begin
            if (trapIsInt && (mtvec_q[1:0] == 2'b01))
                bus.trap_target = trapBase + {26'b0, trapCode, 2'b00};
            else
                bus.trap_target = trapBase;
        end
    end

`ifdef RANGER_VECTORED_MTVEC_EN
    assign modeWrite = (bus.csr_wr_data[1:0] == 2'b01) ? 2'b01 : 2'b00;
`else
    assign modeWrite = 2'b00;
`endif

    // A trap's mepc/mcause/mtval update overrides a same-cycle CSR write to them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            mtvec_q     <= {RESET_MTVEC[31:2], 2'b00};
            mie_q       <= 32'b0;
            mepc_q      <= 32'b0;
            mcause_q    <= 32'b0;
            mtval_q     <= 32'b0;
            meipSync1_q <= 1'b0;
            meipSync2_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            meipSync1_q <= bus.meip_async;
            meipSync2_q <= meipSync1_q;
            if (bus.trap_wr_en) begin
                case (bus.csr_addr)
                    12'h304: mie_q    <= bus.csr_wr_data & MIE_MASK;
                    12'h305: mtvec_q  <= {bus.csr_wr_data[31:2], modeWrite};
                    12'h341: mepc_q   <= {bus.csr_wr_data[31:2], 2'b00};
                    12'h342: mcause_q <= bus.csr_wr_data;
                    12'h343: mtval_q  <= bus.csr_wr_data;
                    default: ;
                endcase
            end
            if (trapFire) begin
                mepc_q   <= {bus.pc[31:2], 2'b00};
                mcause_q <= {trapIsInt, 27'b0, trapCode};
                mtval_q  <= trapIsInt ? 32'b0 : excTval;
            end
        end
    end

    always_comb begin
        rdData = 32'b0;
        case (bus.csr_addr)
            12'h304: rdData = mie_q;
            12'h305: rdData = mtvec_q;
            12'h341: rdData = mepc_q;
            12'h342: rdData = mcause_q;
            12'h343: rdData = mtval_q;
            12'h344: rdData = mipValue;
            default: rdData = 32'b0;
        endcase
    end

    assign bus.trap_rd_data = bus.trap_rd_en ? rdData : 32'b0;
    assign bus.mepc_out     = mepc_q;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: exception vector table plus hand-written
// sequences for FLUSH, HOLD, mret deferral, interrupt priority and reset.
module tb_trap_unit;

    typedef struct {
        string       name;
        logic [5:0]  exc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] faultAddr;
        logic [31:0] expCause;
        logic [31:0] expTval;
        logic [31:0] expMepc;
    } excVec_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    trap_unit_if bus();

    trap_unit #(.RESET_MTVEC(32'h0000_1003)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkRead(input string name, input logic [11:0] addr, input logic [31:0] expected);
        bus.csr_addr   = addr;
        bus.trap_rd_en = 1'b1;
        #1;
        checkOutput(name, bus.trap_rd_data, expected);
        bus.trap_rd_en = 1'b0;
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
        bus.csr_addr    = addr;
        bus.csr_wr_data = data;
        bus.trap_wr_en  = 1'b1;
        tick();
        bus.trap_wr_en  = 1'b0;
    endtask

    task automatic setExc(input logic [5:0] exc);
        {bus.illegal_inst, bus.inst_misaligned, bus.ecall,
         bus.ebreak, bus.store_misaligned, bus.load_misaligned} = exc;
    endtask

    task automatic applyStimulus(input excVec_t v);
        bus.pc         = v.pc;
        bus.inst       = v.inst;
        bus.fault_addr = v.faultAddr;
        setExc(v.exc);
    endtask

    excVec_t vectors[10];
    logic [31:0] expTarget;

    initial begin
        checkCount = 0;
        errorCount = 0;
        // exc bits: {illegal, instMis, ecall, ebreak, storeMis, loadMis}
        vectors[0] = '{"illegal",       6'b100000, 32'h40, 32'hFFFF_FFFF, 32'h0,    32'd2,  32'hFFFF_FFFF, 32'h40};
        vectors[1] = '{"instMis",       6'b010000, 32'h44, 32'h13,        32'h2002, 32'd0,  32'h2002,      32'h44};
        vectors[2] = '{"ecall",         6'b001000, 32'h48, 32'h73,        32'h5555, 32'd11, 32'h0,         32'h48};
        vectors[3] = '{"ebreak",        6'b000100, 32'h4C, 32'h100073,    32'h5555, 32'd3,  32'h0,         32'h4C};
        vectors[4] = '{"storeMis",      6'b000010, 32'h50, 32'h23,        32'h3003, 32'd6,  32'h3003,      32'h50};
        vectors[5] = '{"loadMis",       6'b000001, 32'h56, 32'h03,        32'h1001, 32'd4,  32'h1001,      32'h54};
        vectors[6] = '{"illegalBeats",  6'b101001, 32'h58, 32'hDEAD_BEEF, 32'h7007, 32'd2,  32'hDEAD_BEEF, 32'h58};
        vectors[7] = '{"ecallBeatsEbk", 6'b001100, 32'h5C, 32'h73,        32'h7007, 32'd11, 32'h0,         32'h5C};
        vectors[8] = '{"instMisBeats",  6'b010010, 32'h60, 32'h6F,        32'h6006, 32'd0,  32'h6006,      32'h60};
        vectors[9] = '{"storeBeatsLd",  6'b000011, 32'h64, 32'h23,        32'h8008, 32'd6,  32'h8008,      32'h64};

        rst = 1'b1;
        bus.trap_rd_en = 1'b0; bus.trap_wr_en = 1'b0;
        bus.csr_addr = 12'h0; bus.csr_wr_data = 32'h0;
        bus.global_mie = 1'b0; bus.pc = 32'h0; bus.inst = 32'h0; bus.fault_addr = 32'h0;
        setExc(6'b0);
        bus.msip = 1'b0; bus.mtip = 1'b0; bus.meip_async = 1'b0;
        bus.dbus_wait = 1'b0; bus.mret = 1'b0;
        tick();
        tick();
        checkOutput("resetTrap", {31'b0, bus.trap}, 32'h0);
        checkOutput("resetTarget", bus.trap_target, 32'h0);
        checkOutput("resetMepcOut", bus.mepc_out, 32'h0);
        bus.csr_addr = 12'h305;
        #1;
        checkOutput("rdDataIdle", bus.trap_rd_data, 32'h0);
        rst = 1'b0;
        tick();
        checkRead("resetMtvec", 12'h305, 32'h0000_1000);
        checkRead("resetMcause", 12'h342, 32'h0);

        csrWrite(12'h305, 32'h0000_0100);
        checkRead("mtvecWrite", 12'h305, 32'h0000_0100);
        csrWrite(12'h304, 32'hFFFF_FFFF);
        checkRead("mieMask", 12'h304, 32'h0000_0888);
        csrWrite(12'h304, 32'h0);
        checkRead("unmapped", 12'h300, 32'h0);
        checkRead("mipIdle", 12'h344, 32'h0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i]);
            #1;
            checkOutput({vectors[i].name, "_trap"}, {31'b0, bus.trap}, 32'h1);
            checkOutput({vectors[i].name, "_target"}, bus.trap_target, 32'h100);
            tick();
            checkOutput({vectors[i].name, "_flush"}, {31'b0, bus.trap}, 32'h0);
            setExc(6'b0);
            checkOutput({vectors[i].name, "_mepc"}, bus.mepc_out, vectors[i].expMepc);
            checkRead({vectors[i].name, "_mcause"}, 12'h342, vectors[i].expCause);
            checkRead({vectors[i].name, "_mtval"}, 12'h343, vectors[i].expTval);
            tick();
        end

        // Held exception: trap, FLUSH gap, then trap again.
        bus.pc = 32'h40; bus.inst = 32'hFFFF_FFFF; bus.illegal_inst = 1'b1;
        #1;
        checkOutput("heldTrap1", {31'b0, bus.trap}, 32'h1);
        tick();
        checkOutput("heldFlush", {31'b0, bus.trap}, 32'h0);
        checkOutput("heldFlushTarget", bus.trap_target, 32'h0);
        tick();
        checkOutput("heldTrap2", {31'b0, bus.trap}, 32'h1);
        bus.illegal_inst = 1'b0;
        tick();
        tick();

        csrWrite(12'h341, 32'h0000_0203);
        checkOutput("mepcAlign", bus.mepc_out, 32'h0000_0200);
        checkRead("mepcRead", 12'h341, 32'h0000_0200);

        // mcause write collides with a load-misaligned trap; the trap wins.
        bus.pc = 32'h80; bus.fault_addr = 32'h1001; bus.load_misaligned = 1'b1;
        bus.csr_addr = 12'h342; bus.csr_wr_data = 32'h55; bus.trap_wr_en = 1'b1;
        #1;
        checkOutput("wrTrapTrap", {31'b0, bus.trap}, 32'h1);
        tick();
        bus.trap_wr_en = 1'b0; bus.load_misaligned = 1'b0;
        checkRead("wrTrapMcause", 12'h342, 32'd4);
        checkRead("wrTrapMtval", 12'h343, 32'h1001);
        tick();

        // External interrupt through the synchronizer, vectored when enabled.
        csrWrite(12'h304, 32'h880);
        csrWrite(12'h305, 32'h101);
`ifdef RANGER_VECTORED_MTVEC_EN
        checkRead("mtvecVectored", 12'h305, 32'h101);
`else
        checkRead("mtvecVectored", 12'h305, 32'h100);
`endif
        bus.mtip = 1'b1; bus.meip_async = 1'b1; bus.pc = 32'h90;
        tick();
        checkRead("mipSync1", 12'h344, 32'h080);
        tick();
        checkRead("mipSync2", 12'h344, 32'h880);
        bus.global_mie = 1'b1;
        #1;
        checkOutput("meiTrap", {31'b0, bus.trap}, 32'h1);
`ifdef RANGER_VECTORED_MTVEC_EN
        expTarget = 32'h12C;
`else
        expTarget = 32'h100;
`endif
        checkOutput("meiTarget", bus.trap_target, expTarget);
        tick();
        bus.global_mie = 1'b0; bus.meip_async = 1'b0;
        checkRead("meiMcause", 12'h342, 32'h8000_000B);
        checkRead("meiMtval", 12'h343, 32'h0);
        checkOutput("meiMepc", bus.mepc_out, 32'h90);
        tick();

        // Timer interrupt deferred in HOLD while the data bus stalls.
        csrWrite(12'h304, 32'h080);
        bus.dbus_wait = 1'b1; bus.global_mie = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("holdNoTrap", {31'b0, bus.trap}, 32'h0);
            tick();
        end
        bus.dbus_wait = 1'b0;
        #1;
        checkOutput("holdRelease", {31'b0, bus.trap}, 32'h1);
`ifdef RANGER_VECTORED_MTVEC_EN
        expTarget = 32'h11C;
`else
        expTarget = 32'h100;
`endif
        checkOutput("mtiTarget", bus.trap_target, expTarget);
        tick();
        bus.global_mie = 1'b0;
        checkRead("mtiMcause", 12'h342, 32'h8000_0007);
        tick();

        // mret defers the interrupt by one cycle.
        bus.global_mie = 1'b1; bus.mret = 1'b1;
        #1;
        checkOutput("mretSuppress", {31'b0, bus.trap}, 32'h0);
        tick();
        bus.mret = 1'b0;
        #1;
        checkOutput("mretRetry", {31'b0, bus.trap}, 32'h1);
        tick();
        bus.global_mie = 1'b0;
        tick();

        csrWrite(12'h305, 32'h103);
        checkRead("mtvecMode3", 12'h305, 32'h100);

        // MSI outranks MTI.
        csrWrite(12'h304, 32'h088);
        bus.msip = 1'b1; bus.global_mie = 1'b1;
        #1;
        checkOutput("msiTrap", {31'b0, bus.trap}, 32'h1);
        tick();
        bus.global_mie = 1'b0;
        checkRead("msiMcause", 12'h342, 32'h8000_0003);
        tick();

        // ecall beats a pending MSI.
        bus.global_mie = 1'b1; bus.ecall = 1'b1;
        #1;
        checkOutput("ecallIntTarget", bus.trap_target, 32'h100);
        tick();
        bus.ecall = 1'b0; bus.global_mie = 1'b0;
        checkRead("ecallIntMcause", 12'h342, 32'd11);
        checkRead("ecallIntMtval", 12'h343, 32'h0);
        tick();

        // Asynchronous reset while holding an interrupt.
        bus.msip = 1'b0; bus.global_mie = 1'b1; bus.dbus_wait = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstHoldTrap", {31'b0, bus.trap}, 32'h0);
        bus.dbus_wait = 1'b0;
        #1;
        checkOutput("rstHoldRelease", {31'b0, bus.trap}, 32'h0);
        checkOutput("rstMepcOut", bus.mepc_out, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("postRstTrap", {31'b0, bus.trap}, 32'h0);
        checkRead("postRstMie", 12'h304, 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/trap_unit.md
# trap_unit

Machine-mode trap controller for the Ranger core. It owns the trap CSRs that the CSR file delegates: mtvec, mie, mip, mepc, mcause and mtval. It prioritises synchronous exceptions and enabled interrupts, and issues a one-cycle `trap` pulse with the handler target. It also presents `mepc` as the `mret` return address. It sits beside the CSR file, which supplies `global_mie` and consumes `trap_rd_data` and `trap`.

## Interface
- `RESET_MTVEC`, default 32'h0000_0000: mtvec reset value; bits [1:0] are forced to 0.
- `clk` in 1: global system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `trap_rd_en` in 1: CSR read strobe for trap CSRs.
- `trap_wr_en` in 1: CSR write strobe for trap CSRs.
- `csr_addr` in 12: CSR address.
- `csr_wr_data` in 32: CSR write data.
- `trap_rd_data` out 32: CSR read data (combinational).
- `global_mie` in 1: mstatus.MIE.
- `pc` in 32: PC of the instruction in execute.
- `inst` in 32: instruction word in execute.
- `fault_addr` in 32: misaligned target or data address.
- `illegal_inst`, `inst_misaligned`, `ecall`, `ebreak`, `load_misaligned`, `store_misaligned` in 1 each: exception flags.
- `msip`, `mtip` in 1: synchronous software and timer interrupt sources.
- `meip_async` in 1: external interrupt, asynchronous.
- `dbus_wait` in 1: data bus stall.
- `mret` in 1: mret executing.
- `trap` out 1: trap taken this cycle.
- `trap_target` out 32: handler address, valid while `trap`=1.
- `mepc_out` out 32: current mepc.

## Operation
- CSR map:
  - mie 0x304: bits 11, 7 and 3 writable; all other bits read 0.
  - mtvec 0x305: BASE[31:2]; MODE[1:0] per Configuration.
  - mepc 0x341: bits [1:0] read 0 and are ignored on write.
  - mcause 0x342, mtval 0x343: fully writable.
  - mip 0x344: read-only. MEIP = synchronised `meip_async`, MTIP = `mtip`, MSIP = `msip`.
  - Unmapped addresses read 0.
- `trap_rd_data` is valid whenever `trap_rd_en`=1 and reads 0 otherwise.
- `meip_async` passes through a 2-flop synchronizer before reaching mip.
- Exception priority, highest first, with mcause code:
  - `illegal_inst` (2)
  - `inst_misaligned` (0)
  - `ecall` (11)
  - `ebreak` (3)
  - `store_misaligned` (6)
  - `load_misaligned` (4)
- Interrupt priority: MEI (11) > MSI (3) > MTI (7). An interrupt is pending when `global_mie` and (mip & mie) ≠ 0.
- Exceptions beat interrupts in the same cycle.
- On trap:
  - mepc ← `pc`.
  - mcause ← {is_interrupt, 27'b0, code}.
  - mtval ← `inst` for illegal instruction, `fault_addr` for the misaligned causes, 0 otherwise.
- State machine:
  - RUN:
    - An exception fires immediately.
    - A pending interrupt with `dbus_wait`=1 moves to HOLD and does not trap.
    - A pending interrupt with `dbus_wait`=0 and `mret`=0 traps.
    - Any trap moves to FLUSH.
  - HOLD:
    - An exception traps and moves to FLUSH.
    - If the interrupt is no longer pending, return to RUN.
    - When `dbus_wait` drops, the highest interrupt pending that cycle traps and moves to FLUSH.
  - FLUSH: one cycle. All trap sources are ignored and `trap`=0. Always moves to RUN.
- `mret`=1 suppresses interrupt traps that cycle; the interrupt is re-evaluated next cycle. Exceptions are not suppressed.
- A CSR write and a trap in the same cycle: the trap update wins for mepc, mcause and mtval. Writes to mtvec and mie still apply.

## Timing
- Reset state: state RUN, mtvec = RESET_MTVEC, mie, mepc, mcause and mtval = 0, synchronizer flops 0.
- Reset values of outputs: `trap`=0, `trap_target`=0, `trap_rd_data`=0, `mepc_out`=0.
- Asserting `rst` mid-HOLD or mid-FLUSH returns immediately to RUN and drops `trap`.
- `trap` and `trap_target` are combinational from the current state and inputs, with zero latency. CSR updates land on the next `clk` edge.
- `trap_target` is 0 whenever `trap`=0.
- CSR writes are visible on reads the cycle after `trap_wr_en`.
- `meip_async` reaches mip 2 cycles after it is stable.
- Back-to-back traps are at least 2 cycles apart because of FLUSH.

## Configuration
- `RANGER_VECTORED_MTVEC_EN`:
  - Defined: MODE[1:0] is writable. Value 1 = vectored, where an interrupt targets BASE + 4×code and exceptions target BASE. Values 2 and 3 are written as 0.
  - Undefined: MODE is hardwired 0, writes to it are ignored, and every trap targets BASE.

## Test plan
- Reset, then read 0x305 → RESET_MTVEC; `trap`=0.
- mtvec=0x100, `pc`=0x40, `illegal_inst`=1, `inst`=0xFFFF_FFFF → `trap` for 1 cycle, target 0x100, mepc=0x40, mcause=2, mtval=0xFFFF_FFFF. The next cycle is FLUSH with `trap`=0 even if `illegal_inst` is still held.
- mie=0x880, `global_mie`=1, `mtip`=1 and `meip_async`=1 held ≥2 cycles, vectored mode, mtvec=0x101 → target 0x100+44=0x12C, mcause=0x8000_000B.
- Pending MTI with `dbus_wait`=1 for 3 cycles → `trap`=0 in HOLD; `dbus_wait` falls → `trap`, mcause=0x8000_0007.
- `ecall` together with a pending MSI → mcause=11 (exception), mtval=0.
- Write mepc=0x203 → `mepc_out`=0x200. Write mcause in the same cycle as a `load_misaligned` with `fault_addr`=0x1001 → mcause=4, mtval=0x1001.
